reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised integer register file for the RV32I core, with a per-register busy scoreboard for pipelined issue.
- Provides 2 combinational read ports, 1 writeback port, write-to-read forwarding, and an issue/stall handshake that blocks RAW and WAW hazards until writeback.
- Sits between decode/issue and the ALU/operand mux; the writeback stage drives the write port.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers (power of 2, ≥2); register 0 is hard-wired zero.
- AW, $clog2(NREGS), register address width (derived; not overridden).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rs1_addr  in  AW  read port 1 address.
- rs2_addr  in  AW  read port 2 address.
- rs1_data  out  XLEN  read port 1 data (combinational).
- rs2_data  out  XLEN  read port 2 data (combinational).
- wb_en  in  1  writeback enable.
- wb_addr  in  AW  writeback destination.
- wb_data  in  XLEN  writeback data.
- iss_valid  in  1  decode presents an instruction for issue.
- iss_rs1_used  in  1  instruction reads rs1_addr.
- iss_rs2_used  in  1  instruction reads rs2_addr.
- iss_rd_en  in  1  instruction will write iss_rd.
- iss_rd  in  AW  destination of issuing instruction.
- iss_stall  out  1  hazard present; issue not accepted this cycle.
- flush  in  1  pipeline kill; discard all pending busy marks.

Behaviour:
- Reset (rst=1 at clk edge): all registers ← 0, all busy bits ← 0. Takes priority over wb, issue and flush. After reset: rs*_data=0, iss_stall=0.
- Register 0:
  - Reads always return 0.
  - Writes are ignored.
  - Never marked busy; its address never causes a stall.
- Write: at the clk edge with wb_en=1 and wb_addr≠0, regs[wb_addr] ← wb_data. Also clears busy[wb_addr].
- Read:
  - rsN_data = regs[rsN_addr], combinational, zero latency.
  - Forwarding: if wb_en=1, wb_addr=rsN_addr and rsN_addr≠0, then rsN_data = wb_data in the same cycle.
- Effective busy: eff_busy[i] = busy[i] & ~(wb_en & wb_addr==i). Same-cycle writeback satisfies the hazard.
- Stall: iss_stall = iss_valid & ((iss_rs1_used & eff_busy[rs1_addr]) | (iss_rs2_used & eff_busy[rs2_addr]) | (iss_rd_en & eff_busy[iss_rd])). iss_stall=0 whenever iss_valid=0.
- Issue accepted: when iss_valid=1, iss_stall=0 and flush=0. If iss_rd_en=1 and iss_rd≠0, busy[iss_rd] ← 1 at the edge.
- Same-cycle issue and writeback to the same register: the set from issue wins, so busy stays 1.
- Flush:
  - At the edge, all busy bits ← 0.
  - Issue in the same cycle is ignored.
  - A writeback in the same cycle still updates register data.
- Busy state: a plain register vector, no FSM. Each bit has two states, FREE and BUSY. FREE→BUSY on accepted issue; BUSY→FREE on wb, flush or rst.
- A writeback to a non-busy register is legal: data is written, busy is unchanged.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - Writeback-to-read forwarding is active.
  - eff_busy includes the same-cycle writeback clear, as above.
- Undefined:
  - rsN_data = regs[rsN_addr] only.
  - eff_busy = busy.
  - Consequence: a dependent instruction stalls one extra cycle and reads the written value the cycle after writeback.

Decomposition:
- rf_pkg holds:
  - XLEN_DEF=32, NREGS_DEF=32.
  - typedef reg_addr_t (logic [AW-1:0]).
  - typedef xlen_t (logic [XLEN-1:0]).
  - localparam ZERO_REG=0.
- Sub-module rf_scoreboard contains:
  - the busy vector and the eff_busy/stall logic;
  - the set/clear/flush/reset priority logic.
- reg_file_sb instantiates rf_scoreboard and contains the storage array and read muxes.

Test Plan:
- Reset: after rst=1 for 1 cycle, read every address → all 0; iss_valid=1 with every rs/rd used → iss_stall=0.
- x0 handling: wb_en=1, wb_addr=0, wb_data=32'hDEADBEEF → rs1_addr=0 reads 0. Issue with iss_rd=0 → a following read of rs1=0 gives no stall.
- RAW stall and clear:
  - Cycle 1: issue rd=5 → busy[5]=1.
  - Next cycle: iss_valid with rs1=5 used → iss_stall=1.
  - Later: wb_en=1, wb_addr=5, wb_data=32'h12345678 → that cycle iss_stall=0 and rs1_data=32'h12345678 (RF_BYPASS_EN). Without the macro, stall=1 that cycle, then stall=0 and data=32'h12345678 the next cycle.
- WAW and same-cycle set/clear:
  - With busy[7]=1, issue rd=7 → stall.
  - Then wb to 7 together with issue rd=7 (bypass on) → issue accepted and busy[7] remains 1.
- Flush: set busy[3], busy[9], busy[30]; flush=1 with iss_valid=1, rd=4 → next cycle all busy 0 and busy[4]=0. A simultaneous wb of 32'hA5A5A5A5 to reg 3 is readable afterward.
- Reset mid-operation: busy[12]=1, reg12=32'h55; assert rst together with wb_en=1 to reg12 → next cycle reg12=0, busy[12]=0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and constants for the RV32I integer register file with busy scoreboard.
package rf_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);
    localparam int ZERO_REG  = 0;

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xlen_t;

endpackage : rf_pkg

// File: rtl/rf_scoreboard.sv
// Per-register busy tracking and RAW/WAW issue stall for reg_file_sb.
// RF_BYPASS_EN: when defined, a same-cycle writeback satisfies a pending hazard.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter  int NREGS = NREGS_DEF,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    input  logic          iss_valid,
    input  logic          iss_rs1_used,
    input  logic          iss_rs2_used,
    input  logic          iss_rd_en,
    input  logic [AW-1:0] iss_rd,
    output logic          iss_stall
);

    localparam logic [AW-1:0] ZERO_A = AW'(ZERO_REG);

    logic [NREGS-1:0] busy_r;
    logic [NREGS-1:0] busy_nxt_s;
    logic [NREGS-1:0] wb_hit_s;
    logic [NREGS-1:0] set_s;
    logic [NREGS-1:0] eff_busy_s;
    logic             stall_s;
    logic             accept_s;

    // One-hot decode of the writeback destination
    always_comb begin
        wb_hit_s = '0;
        if (wb_en) begin
            wb_hit_s[wb_addr] = 1'b1;
        end else begin
            wb_hit_s = '0;
        end
    end

    // Busy view used for hazard detection
    always_comb begin
`ifdef RF_BYPASS_EN
        eff_busy_s = busy_r & ~wb_hit_s;
`else
        eff_busy_s = busy_r;
`endif
    end

    // Hazard check against both sources and the destination
    always_comb begin
        stall_s = 1'b0;
        if (iss_valid) begin
            stall_s = (iss_rs1_used & eff_busy_s[rs1_addr]) |
                      (iss_rs2_used & eff_busy_s[rs2_addr]) |
                      (iss_rd_en    & eff_busy_s[iss_rd]);
        end else begin
            stall_s = 1'b0;
        end
    end

    assign accept_s  = iss_valid & ~stall_s & ~flush;
    assign iss_stall = stall_s;

    // One-hot decode of the busy mark requested by an accepted issue
    always_comb begin
        set_s = '0;
        if (accept_s && iss_rd_en && (iss_rd != ZERO_A)) begin
            set_s[iss_rd] = 1'b1;
        end else begin
            set_s = '0;
        end
    end

    // Clear on writeback first, then set on issue so a same-cycle set wins
    always_comb begin
        busy_nxt_s    = (busy_r & ~wb_hit_s) | set_s;
        busy_nxt_s[0] = 1'b0;
    end

    // Busy vector: reset beats flush beats normal update
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= '0;
        end else if (flush) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

endmodule : rf_scoreboard

// File: rtl/reg_file_sb.sv
// Integer register file (2R/1W, x0 hard-wired zero) with issue scoreboard.
// RF_BYPASS_EN: when defined, writeback data is forwarded to the read ports in the same cycle.
module reg_file_sb
    import rf_pkg::*;
#(
    parameter  int XLEN  = XLEN_DEF,
    parameter  int NREGS = NREGS_DEF,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            iss_valid,
    input  logic            iss_rs1_used,
    input  logic            iss_rs2_used,
    input  logic            iss_rd_en,
    input  logic [AW-1:0]   iss_rd,
    output logic            iss_stall,
    input  logic            flush
);

    localparam logic [AW-1:0] ZERO_A = AW'(ZERO_REG);

    logic [XLEN-1:0] regs_r [NREGS];
    logic [XLEN-1:0] rs1_data_s;
    logic [XLEN-1:0] rs2_data_s;

    // Architectural storage; entry 0 is never written
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wb_en && (wb_addr != ZERO_A)) begin
            regs_r[wb_addr] <= wb_data;
        end
    end

    // Read port 1 mux
    always_comb begin
        rs1_data_s = '0;
        if (rs1_addr == ZERO_A) begin
            rs1_data_s = '0;
        end
`ifdef RF_BYPASS_EN
        else if (wb_en && (wb_addr == rs1_addr)) begin
            rs1_data_s = wb_data;
        end
`endif
        else begin
            rs1_data_s = regs_r[rs1_addr];
        end
    end

    // Read port 2 mux
    always_comb begin
        rs2_data_s = '0;
        if (rs2_addr == ZERO_A) begin
            rs2_data_s = '0;
        end
`ifdef RF_BYPASS_EN
        else if (wb_en && (wb_addr == rs2_addr)) begin
            rs2_data_s = wb_data;
        end
`endif
        else begin
            rs2_data_s = regs_r[rs2_addr];
        end
    end

    assign rs1_data = rs1_data_s;
    assign rs2_data = rs2_data_s;

    rf_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .iss_valid    (iss_valid),
        .iss_rs1_used (iss_rs1_used),
        .iss_rs2_used (iss_rs2_used),
        .iss_rd_en    (iss_rd_en),
        .iss_rd       (iss_rd),
        .iss_stall    (iss_stall)
    );

endmodule : reg_file_sb

// File: tb/tb_reg_file_sb.sv
// Scoreboard-style bench for reg_file_sb; expectations follow RF_BYPASS_EN if defined.
module tb_reg_file_sb;
    import rf_pkg::*;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr, wb_addr, iss_rd;
    logic [31:0] rs1_data, rs2_data, wb_data;
    logic        wb_en, iss_valid, iss_rs1_used, iss_rs2_used, iss_rd_en, iss_stall, flush;

    int          sel_q[$];
    logic [31:0] exp_q[$];
    string       name_q[$];
    int          tests_run    = 0;
    int          tests_failed = 0;

    always #5 clk = ~clk;

    reg_file_sb dut (
        .clk          (clk),
        .rst          (rst),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .iss_valid    (iss_valid),
        .iss_rs1_used (iss_rs1_used),
        .iss_rs2_used (iss_rs2_used),
        .iss_rd_en    (iss_rd_en),
        .iss_rd       (iss_rd),
        .iss_stall    (iss_stall),
        .flush        (flush)
    );

    // sel: 0 = rs1_data, 1 = rs2_data, 2 = iss_stall
    task automatic expect_out(input int sel, input logic [31:0] v, input string nm);
        sel_q.push_back(sel);
        exp_q.push_back(v);
        name_q.push_back(nm);
    endtask

    task automatic idle();
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
        iss_valid = 1'b0; iss_rs1_used = 1'b0; iss_rs2_used = 1'b0;
        iss_rd_en = 1'b0; iss_rd = 5'd0; flush = 1'b0;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic u1, input logic [4:0] a1, input logic u2, input logic [4:0] a2,
                         input logic rde, input logic [4:0] rd);
        iss_valid = 1'b1;
        iss_rs1_used = u1; rs1_addr = a1;
        iss_rs2_used = u2; rs2_addr = a2;
        iss_rd_en = rde; iss_rd = rd;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
    endtask

    // Monitor: outputs are combinational, so every queued expectation is due at the next falling edge
    initial begin : monitor
        int          sel;
        logic [31:0] e;
        logic [31:0] act;
        string       nm;
        forever begin
            @(negedge clk);
            while (sel_q.size() != 0) begin
                sel = sel_q.pop_front();
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                case (sel)
                    0:       act = rs1_data;
                    1:       act = rs2_data;
                    default: act = {31'd0, iss_stall};
                endcase
                tests_run++;
                if (act !== e) begin
                    tests_failed++;
                    $display("FAIL %s: got %h expected %h", nm, act, e);
                end
            end
        end
    end

    initial begin : stimulus
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Reset: every register reads zero on both ports
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(31 - i);
            expect_out(0, 32'h0, "reset_rs1");
            expect_out(1, 32'h0, "reset_rs2");
            step();
        end
        issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3);
        expect_out(2, 32'h0, "reset_no_stall");
        step();
        idle();
        issue(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0);
        expect_out(2, 32'h1, "busy3_raw_stall");
        step();
        idle(); flush = 1'b1;
        step();
        idle();
        issue(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0);
        expect_out(2, 32'h0, "flush_clears_3");
        step();

        // Forwarding of a write to a non-busy register
        idle(); wb(5'd1, 32'h11111111); rs1_addr = 5'd1;
        expect_out(0, BYP ? 32'h11111111 : 32'h0, "fwd_same_cycle");
        step();
        idle(); rs2_addr = 5'd1;
        expect_out(1, 32'h11111111, "read_after_wb");
        step();

        // x0 handling
        idle(); wb(5'd0, 32'hDEADBEEF); rs1_addr = 5'd0;
        expect_out(0, 32'h0, "x0_wb_no_fwd");
        step();
        idle(); rs1_addr = 5'd0;
        expect_out(0, 32'h0, "x0_read_zero");
        issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0);
        expect_out(2, 32'h0, "x0_issue_rd");
        step();
        idle(); issue(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0);
        expect_out(2, 32'h0, "x0_never_busy");
        step();

        // RAW stall and clear
        idle(); issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5);
        expect_out(2, 32'h0, "raw_issue_rd5");
        step();
        idle(); iss_rs1_used = 1'b1; rs1_addr = 5'd5;
        expect_out(2, 32'h0, "no_valid_no_stall");
        step();
        idle(); issue(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
        expect_out(2, 32'h1, "raw_stall");
        step();
        wb(5'd5, 32'h12345678);
        expect_out(2, BYP ? 32'h0 : 32'h1, "raw_wb_cycle_stall");
        expect_out(0, BYP ? 32'h12345678 : 32'h0, "raw_wb_cycle_data");
        step();
        idle(); issue(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
        expect_out(2, 32'h0, "raw_after_wb_stall");
        expect_out(0, 32'h12345678, "raw_after_wb_data");
        step();

        // WAW and same-cycle set/clear
        idle(); issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7);
        expect_out(2, 32'h0, "waw_first");
        step();
        expect_out(2, 32'h1, "waw_stall");
        step();
        wb(5'd7, 32'h00000077);
        expect_out(2, BYP ? 32'h0 : 32'h1, "waw_wb_cycle");
        step();
        idle(); issue(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0);
        expect_out(2, BYP ? 32'h1 : 32'h0, "waw_set_wins");
        step();
        idle(); flush = 1'b1;
        step();

        // Flush with concurrent issue and writeback
        idle(); issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3);
        expect_out(2, 32'h0, "fl_set3");
        step();
        iss_rd = 5'd9;
        expect_out(2, 32'h0, "fl_set9");
        step();
        iss_rd = 5'd30;
        expect_out(2, 32'h0, "fl_set30");
        step();
        idle(); issue(1'b1, 5'd9, 1'b1, 5'd30, 1'b0, 5'd0);
        expect_out(2, 32'h1, "fl_busy_before");
        step();
        idle(); issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4);
        flush = 1'b1; wb(5'd3, 32'hA5A5A5A5);
        expect_out(2, 32'h0, "fl_cycle_stall");
        step();
        idle(); issue(1'b1, 5'd3, 1'b1, 5'd9, 1'b1, 5'd30);
        expect_out(2, 32'h0, "fl_all_clear");
        expect_out(0, 32'hA5A5A5A5, "fl_wb_data");
        expect_out(1, 32'h0, "fl_reg9_zero");
        step();
        idle(); issue(1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0);
        expect_out(2, 32'h0, "fl_issue_ignored");
        step();

        // Reset in the middle of operation
        idle(); wb(5'd12, 32'h00000055);
        issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd12);
        expect_out(2, 32'h0, "rs_setup");
        step();
        idle(); rs1_addr = 5'd12;
        iss_valid = 1'b1; iss_rs2_used = 1'b1; rs2_addr = 5'd12;
        expect_out(0, 32'h00000055, "rs_reg12_before");
        expect_out(2, 32'h1, "rs_busy12_before");
        step();
        idle(); rst = 1'b1; wb(5'd12, 32'h00000099);
        step();
        rst = 1'b0; idle();
        issue(1'b1, 5'd12, 1'b1, 5'd30, 1'b0, 5'd0);
        expect_out(0, 32'h0, "rs_reg12_after");
        expect_out(2, 32'h0, "rs_busy_after");
        step();
        idle(); rs1_addr = 5'd5; rs2_addr = 5'd3;
        expect_out(0, 32'h0, "rs_reg5_after");
        expect_out(1, 32'h0, "rs_reg3_after");
        step();

        @(negedge clk);
        #1;
        tests_run++;
        if (sel_q.size() != 0) begin
            tests_failed++;
            $display("FAIL queue_drain: got %0d pending expected 0", sel_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule : tb_reg_file_sb
